// File: rtl/mxint8_block_quantizer_if.sv
// mxint8_block_quantizer_if
//   Handshake bundle for the FP32 -> MXINT8 block quantizer.
//   Input side : i_valid / o_ready / i_float32 / i_last  (one float per beat)
//   Output side: o_valid / i_ready / o_scale / o_elements (one MX block per beat)
//   Signal names keep the quantizer's point of view (i_* into it, o_* out of it).
//   Modports:
//     slave  - the quantizer itself
//     master - the environment feeding floats and consuming blocks
interface mxint8_block_quantizer_if #(
  parameter int BLOCK_SIZE = 32
);
  logic                    i_valid;
  logic                    o_ready;
  logic [31:0]             i_float32;
  logic                    i_last;
  logic                    o_valid;
  logic                    i_ready;
  logic [7:0]              o_scale;
  logic [8*BLOCK_SIZE-1:0] o_elements;

  modport slave (
    input  i_valid, i_float32, i_last, i_ready,
    output o_ready, o_valid, o_scale, o_elements
  );

  modport master (
    output i_valid, i_float32, i_last, i_ready,
    input  o_ready, o_valid, o_scale, o_elements
  );
endinterface

// File: rtl/mxint8_block_quantizer.sv
// mxint8_block_quantizer
//   Streaming FP32 -> MXINT8 block quantizer. Collects up to BLOCK_SIZE float32
//   values, takes the largest effective biased exponent as the shared E8M0
//   scale, then quantizes one element per cycle to 8-bit two's complement
//   (1.6 fixed point) and presents the whole block on the output handshake.
//
//   Ports:
//     i_clk   - clock, all state changes on the rising edge
//     i_rst_n - synchronous active-low reset
//     bus     - mxint8_block_quantizer_if.slave (input float stream, output block)
//
//   Optional feature (compile-time macro MXINT8_QUANT_RNE_EN):
//     defined   - round-to-nearest-even on the element magnitude
//     undefined - truncate the magnitude toward zero (no rounding logic built)
module mxint8_block_quantizer #(
  parameter int BLOCK_SIZE = 32
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  mxint8_block_quantizer_if.slave       bus
);

  localparam int IW = $clog2(BLOCK_SIZE);
  localparam int CW = IW + 1;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    QUANT = 2'd1,
    OUT   = 2'd2
  } state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg;
  logic [CW-1:0]   q_cnt_reg;
  logic [7:0]      max_exp_reg;
  logic            nan_seen_reg;
  logic [7:0]      scale_reg;

  logic [31:0]     buf_mem [BLOCK_SIZE];
  logic [31:0]     rd_data_reg;
  logic            rd_valid_reg;
  logic [7:0]      elem_reg [BLOCK_SIZE];

  // ---------------- handshake decode ----------------
  logic       in_hs, fill_done, quant_done, out_hs;
  logic [7:0] in_exp, in_eff;

  assign in_hs      = bus.i_valid && (state_reg == FILL);
  assign fill_done  = in_hs && (bus.i_last || (cnt_reg == CW'(BLOCK_SIZE - 1)));
  assign quant_done = (state_reg == QUANT) && (q_cnt_reg == CW'(BLOCK_SIZE));
  assign out_hs     = (state_reg == OUT) && bus.i_ready;

  assign in_exp = bus.i_float32[30:23];
  assign in_eff = (in_exp == 8'd0) ? 8'd1 : in_exp;

  // ---------------- FSM ----------------
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state_reg <= FILL;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      FILL:    if (fill_done)  state_next = QUANT;
      QUANT:   if (quant_done) state_next = OUT;
      OUT:     if (out_hs)     state_next = FILL;
      default:                 state_next = FILL;
    endcase
  end

  assign bus.o_ready = (state_reg == FILL);
  assign bus.o_valid = (state_reg == OUT);
  assign bus.o_scale = scale_reg;

  // ---------------- block bookkeeping ----------------
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      cnt_reg      <= '0;
      q_cnt_reg    <= '0;
      max_exp_reg  <= 8'd1;
      nan_seen_reg <= 1'b0;
      scale_reg    <= 8'd0;
    end else begin
      if (in_hs) begin
        cnt_reg <= cnt_reg + CW'(1);
        if (in_exp == 8'hFF)      nan_seen_reg <= 1'b1;
        if (in_eff > max_exp_reg) max_exp_reg  <= in_eff;
      end
      if (out_hs) begin
        cnt_reg      <= '0;
        max_exp_reg  <= 8'd1;
        nan_seen_reg <= 1'b0;
      end
      // q_cnt walks 0..BLOCK_SIZE: read address leads the write index by one
      // because the buffer read is registered.
      if (fill_done)               q_cnt_reg <= '0;
      else if (state_reg == QUANT) q_cnt_reg <= q_cnt_reg + CW'(1);
      if (quant_done) scale_reg <= nan_seen_reg ? 8'hFF : max_exp_reg;
    end
  end

  // ---------------- input buffer (registered read) ----------------
  always_ff @(posedge i_clk) begin
    if (in_hs) buf_mem[cnt_reg[IW-1:0]] <= bus.i_float32;
    rd_data_reg <= buf_mem[q_cnt_reg[IW-1:0]];
  end

  // Slots at or beyond cnt were never written for this block (partial block);
  // they read as +0.0 regardless of stale buffer contents.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) rd_valid_reg <= 1'b0;
    else          rd_valid_reg <= (q_cnt_reg < cnt_reg);
  end

  // ---------------- element quantizer ----------------
  logic [31:0] q_word;
  logic [7:0]  q_exp, q_eff, q_shift;
  logic [23:0] q_sig;
  logic [8:0]  q_total;
  logic [24:0] q_mag_full;
  logic [6:0]  q_mag;
  logic [7:0]  q_elem;

  assign q_word  = rd_valid_reg ? rd_data_reg : 32'd0;
  assign q_exp   = q_word[30:23];
  assign q_eff   = (q_exp == 8'd0) ? 8'd1 : q_exp;
  assign q_sig   = {(q_exp != 8'd0), q_word[22:0]};
  // max_exp is the block maximum, so the subtraction never goes negative.
  assign q_shift = max_exp_reg - q_eff;
  assign q_total = 9'd17 + {1'b0, q_shift};

`ifdef MXINT8_QUANT_RNE_EN
  // 42 fraction bits below the integer part cover the largest shift that can
  // still produce a nonzero result, so the sticky OR loses nothing.
  logic [65:0] q_ext;
  logic [23:0] q_trunc;
  logic        q_guard, q_sticky, q_round_up;

  assign q_ext      = {q_sig, 42'd0} >> q_total;
  assign q_trunc    = q_ext[65:42];
  assign q_guard    = q_ext[41];
  assign q_sticky   = |q_ext[40:0];
  assign q_round_up = q_guard && (q_sticky || q_trunc[0]);
  assign q_mag_full = {1'b0, q_trunc} + {24'd0, q_round_up};
`else
  logic [23:0] q_trunc;

  assign q_trunc    = q_sig >> q_total;
  assign q_mag_full = {1'b0, q_trunc};
`endif

  // Saturate at 127 so -128 is never emitted; no scale adjustment on overflow.
  assign q_mag  = (q_shift >= 8'd25)        ? 7'd0   :
                  (q_mag_full > 25'd127)    ? 7'd127 : q_mag_full[6:0];
  assign q_elem = nan_seen_reg ? 8'd0 :
                  (q_word[31] ? (8'd0 - {1'b0, q_mag}) : {1'b0, q_mag});

  logic          q_write;
  logic [IW-1:0] q_wr_idx;

  assign q_write  = (state_reg == QUANT) && (q_cnt_reg != '0);
  assign q_wr_idx = IW'(q_cnt_reg - CW'(1));

  // ---------------- element registers ----------------
  generate
    for (genvar gi = 0; gi < BLOCK_SIZE; gi++) begin : g_elem
      always_ff @(posedge i_clk) begin
        if (!i_rst_n || fill_done)                     elem_reg[gi] <= 8'd0;
        else if (q_write && (q_wr_idx == IW'(gi)))     elem_reg[gi] <= q_elem;
      end
      assign bus.o_elements[8*gi +: 8] = elem_reg[gi];
    end
  endgenerate

endmodule
